// File: rtl/pl_ctrl_regs_axil_if.sv
// pl_ctrl_regs_axil_if
// AXI4-Lite bus bundle between the PS-side master (through the interconnect)
// and the PL control register bank.
//
// Signals (master drives / slave drives):
//   awaddr, awvalid / awready          write address channel
//   wdata, wstrb, wvalid / wready      write data channel
//   bready / bresp, bvalid             write response channel
//   araddr, arvalid / arready          read address channel
//   rready / rdata, rresp, rvalid      read data channel
interface pl_ctrl_regs_axil_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/pl_ctrl_regs_axil.sv
// pl_ctrl_regs_axil
// Parametrised AXI4-Lite slave register bank for the PL control unit.
// Register index i lives at byte address i*(C_DATA_WIDTH/8):
//   [0, C_NUM_RW)            read/write control registers -> ctrl_out
//   next C_NUM_RO indices     read-only status registers <- status_in
//   then IRQ_STAT (write-1-to-clear), IRQ_EN (read/write), CMD (write-only pulse)
// Anything above CMD is unmapped and answers SLVERR.
//
// Ports:
//   ACLK, ARESET   clock, asynchronous active-high reset
//   s_axi          AXI4-Lite slave bus (pl_ctrl_regs_axil_if.slave)
//   ctrl_out       control register contents, register k at slice k
//   status_in      status register sources, sampled when read
//                  (one unused slice is kept when C_NUM_RO is 0)
//   irq_evt        per-bit interrupt event pulses into IRQ_STAT
//   cmd_pulse      one-cycle strobes produced by CMD writes
//   irq            registered |(IRQ_STAT & IRQ_EN)
module pl_ctrl_regs_axil #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_RW     = 4,
  parameter int C_NUM_RO     = 2
) (
  input  logic                                                ACLK,
  input  logic                                                ARESET,
  pl_ctrl_regs_axil_if.slave                                  s_axi,
  output logic [C_NUM_RW*C_DATA_WIDTH-1:0]                    ctrl_out,
  input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_DATA_WIDTH-1:0] status_in,
  input  logic [C_DATA_WIDTH-1:0]                             irq_evt,
  output logic [C_DATA_WIDTH-1:0]                             cmd_pulse,
  output logic                                                irq
);

  localparam int          STRB_WIDTH   = C_DATA_WIDTH / 8;
  localparam int          ADDR_LSB     = $clog2(STRB_WIDTH);
  localparam int unsigned NUM_RW       = C_NUM_RW;
  localparam int unsigned NUM_RO       = C_NUM_RO;
  localparam int unsigned IDX_IRQ_STAT = NUM_RW + NUM_RO;
  localparam int unsigned IDX_IRQ_EN   = IDX_IRQ_STAT + 1;
  localparam int unsigned IDX_CMD      = IDX_IRQ_STAT + 2;
  localparam int unsigned NUM_REGS     = IDX_IRQ_STAT + 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                    awready_q, wready_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic                    aw_held, w_held;
  logic [C_ADDR_WIDTH-1:0] awaddr_q;
  logic [C_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    wr_commit;
  int unsigned             wr_idx;
  logic [C_DATA_WIDTH-1:0] wr_mask;
  logic [C_DATA_WIDTH-1:0] irq_clr;

  logic                    arready_q, rvalid_q;
  logic [C_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]              rresp_q;
  int unsigned             rd_idx;
  logic [C_DATA_WIDTH-1:0] rd_data;
  logic [1:0]              rd_resp;

  logic [C_DATA_WIDTH-1:0] rw_q [C_NUM_RW];
  logic [C_DATA_WIDTH-1:0] irq_stat_q, irq_en_q, cmd_pulse_q;
  logic                    irq_q;

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign cmd_pulse = cmd_pulse_q;
  assign irq       = irq_q;

  for (genvar k = 0; k < C_NUM_RW; k++) begin : g_ctrl_out
    assign ctrl_out[k*C_DATA_WIDTH +: C_DATA_WIDTH] = rw_q[k];
  end

  // The update fires once address and data are both captured; the done
  // flags are cleared in that same cycle, so a write commits exactly once.
  assign wr_commit = aw_held && w_held && !bvalid_q;
  assign wr_idx    = 32'(awaddr_q >> ADDR_LSB);
  assign rd_idx    = 32'(s_axi.araddr >> ADDR_LSB);

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      wr_mask[b*8 +: 8] = {8{wstrb_q[b]}};
    end
  end

  assign irq_clr = (wr_commit && (wr_idx == IDX_IRQ_STAT)) ? (wdata_q & wr_mask) : '0;

  // Write channel: AW and W are captured independently. READY only returns
  // after the response has been taken, which limits us to one write in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (awready_q && s_axi.awvalid) begin
        awready_q <= 1'b0;
        aw_held   <= 1'b1;
        awaddr_q  <= s_axi.awaddr;
      end else if (!aw_held && !bvalid_q && !awready_q) begin
        awready_q <= 1'b1;
      end

      if (wready_q && s_axi.wvalid) begin
        wready_q <= 1'b0;
        w_held   <= 1'b1;
        wdata_q  <= s_axi.wdata;
        wstrb_q  <= s_axi.wstrb;
      end else if (!w_held && !bvalid_q && !wready_q) begin
        wready_q <= 1'b1;
      end

      if (wr_commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (wr_idx >= NUM_REGS) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Register file. An event bit is ORed in after the clear so a new event
  // arriving with a W1C of the same bit is never lost.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < C_NUM_RW; k++) begin
        rw_q[k] <= '0;
      end
      irq_stat_q  <= '0;
      irq_en_q    <= '0;
      cmd_pulse_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      cmd_pulse_q <= '0;
      irq_stat_q  <= (irq_stat_q & ~irq_clr) | irq_evt;
      irq_q       <= |(irq_stat_q & irq_en_q);
      if (wr_commit) begin
        for (int unsigned k = 0; k < NUM_RW; k++) begin
          if (wr_idx == k) begin
            rw_q[k] <= (rw_q[k] & ~wr_mask) | (wdata_q & wr_mask);
          end
        end
        if (wr_idx == IDX_IRQ_EN) begin
          irq_en_q <= (irq_en_q & ~wr_mask) | (wdata_q & wr_mask);
        end
        if (wr_idx == IDX_CMD) begin
          cmd_pulse_q <= wdata_q & wr_mask;
        end
      end
    end
  end

  // Read mux; CMD and unmapped indices fall through to zero.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    for (int unsigned k = 0; k < NUM_RW; k++) begin
      if (rd_idx == k) rd_data = rw_q[k];
    end
    for (int unsigned j = 0; j < NUM_RO; j++) begin
      if (rd_idx == NUM_RW + j) rd_data = status_in[j*C_DATA_WIDTH +: C_DATA_WIDTH];
    end
    if (rd_idx == IDX_IRQ_STAT) rd_data = irq_stat_q;
    if (rd_idx == IDX_IRQ_EN)   rd_data = irq_en_q;
    if (rd_idx >= NUM_REGS)     rd_resp = RESP_SLVERR;
  end

  // Read channel: data is registered at the AR handshake, so a write that
  // commits on the same edge is not visible to this read.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (arready_q && s_axi.arvalid) begin
        arready_q <= 1'b0;
        rvalid_q  <= 1'b1;
        rdata_q   <= rd_data;
        rresp_q   <= rd_resp;
      end else if (rvalid_q && s_axi.rready) begin
        rvalid_q <= 1'b0;
      end else if (!rvalid_q && !arready_q) begin
        arready_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pl_ctrl_regs_axil.sv
// tb_pl_ctrl_regs_axil
// Directed bench for pl_ctrl_regs_axil (32-bit data, 6-bit address, 4 RW,
// 2 RO): a vector table of single reads/writes followed by hand-timed
// sequences for handshake ordering, interrupts, command pulses and reset.
module tb_pl_ctrl_regs_axil;

  localparam int DW      = 32;
  localparam int AW      = 6;
  localparam int TIMEOUT = 50;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic           ACLK;
  logic           ARESET;
  logic [4*DW-1:0] ctrl_out;
  logic [2*DW-1:0] status_in;
  logic [DW-1:0]  irq_evt;
  logic [DW-1:0]  cmd_pulse;
  logic           irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_write;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  pl_ctrl_regs_axil_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pl_ctrl_regs_axil #(
    .C_DATA_WIDTH(DW),
    .C_ADDR_WIDTH(AW),
    .C_NUM_RW(4),
    .C_NUM_RO(2)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .s_axi(bus.slave),
    .ctrl_out(ctrl_out),
    .status_in(status_in),
    .irq_evt(irq_evt),
    .cmd_pulse(cmd_pulse),
    .irq(irq)
  );

  // 100 MHz free-running clock
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Advance to just after the next rising edge, where inputs are driven and
  // outputs sampled.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL timeout %s: got no handshake, expected one within %0d cycles", name, TIMEOUT);
  endtask

  task automatic wait_bvalid_and_ack(output logic [1:0] resp);
    int n = 0;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < TIMEOUT) begin
      step();
      n++;
    end
    if (!bus.bvalid) timeout_fail("bvalid");
    resp = bus.bresp;
    step();
    bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0, aw_hs, w_hs;
    int n = 0;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    while (!(aw_ok && w_ok) && n < TIMEOUT) begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      step();
      n++;
      if (aw_hs) begin aw_ok = 1; bus.awvalid = 1'b0; end
      if (w_hs)  begin w_ok = 1;  bus.wvalid  = 1'b0; end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(aw_ok && w_ok)) timeout_fail("write accept");
    wait_bvalid_and_ack(resp);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_ok = 0, ar_hs;
    int n = 0;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!ar_ok && n < TIMEOUT) begin
      ar_hs = bus.arvalid && bus.arready;
      step();
      n++;
      if (ar_hs) begin ar_ok = 1; bus.arvalid = 1'b0; end
    end
    bus.arvalid = 1'b0;
    if (!ar_ok) timeout_fail("read accept");
    bus.rready = 1'b1;
    n = 0;
    while (!bus.rvalid && n < TIMEOUT) begin
      step();
      n++;
    end
    if (!bus.rvalid) timeout_fail("rvalid");
    data = bus.rdata;
    resp = bus.rresp;
    step();
    bus.rready = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    logic [31:0] rd;
    logic [1:0]  rsp;
    if (v.is_write) begin
      axi_write(v.addr, v.data, v.strb, rsp);
      check_output({v.name, " bresp"}, 64'(rsp), 64'(v.exp_resp));
    end else begin
      axi_read(v.addr, rd, rsp);
      check_output({v.name, " rdata"}, 64'(rd), 64'(v.exp_data));
      check_output({v.name, " rresp"}, 64'(rsp), 64'(v.exp_resp));
    end
  endtask

  // Main sequence: reset, vector table, then the multi-cycle corner cases.
  initial begin
    logic [31:0] rd;
    logic [1:0]  rsp;
    int n;

    ARESET      = 1'b1;
    status_in   = {32'h1234_5678, 32'hCAFE_0000};
    irq_evt     = '0;
    bus.awaddr  = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wstrb   = '0; bus.wvalid = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    vecs.push_back(vec_t'{1'b1, 6'h00, 32'h0000_0001, 4'hF, 32'h0,          OKAY,   "wr rw0"});
    vecs.push_back(vec_t'{1'b1, 6'h04, 32'h0000_0002, 4'hF, 32'h0,          OKAY,   "wr rw1"});
    vecs.push_back(vec_t'{1'b1, 6'h08, 32'h0000_0003, 4'hF, 32'h0,          OKAY,   "wr rw2"});
    vecs.push_back(vec_t'{1'b1, 6'h0C, 32'h0000_0004, 4'hF, 32'h0,          OKAY,   "wr rw3"});
    vecs.push_back(vec_t'{1'b0, 6'h00, 32'h0,         4'h0, 32'h0000_0001,  OKAY,   "rd rw0"});
    vecs.push_back(vec_t'{1'b0, 6'h04, 32'h0,         4'h0, 32'h0000_0002,  OKAY,   "rd rw1"});
    vecs.push_back(vec_t'{1'b0, 6'h08, 32'h0,         4'h0, 32'h0000_0003,  OKAY,   "rd rw2"});
    vecs.push_back(vec_t'{1'b0, 6'h0C, 32'h0,         4'h0, 32'h0000_0004,  OKAY,   "rd rw3"});
    vecs.push_back(vec_t'{1'b0, 6'h0E, 32'h0,         4'h0, 32'h0000_0004,  OKAY,   "rd rw3 low bits ignored"});
    vecs.push_back(vec_t'{1'b1, 6'h04, 32'hAABB_CCDD, 4'h5, 32'h0,          OKAY,   "wr rw1 strobed"});
    vecs.push_back(vec_t'{1'b0, 6'h04, 32'h0,         4'h0, 32'h00BB_00DD,  OKAY,   "rd rw1 strobed"});
    vecs.push_back(vec_t'{1'b0, 6'h10, 32'h0,         4'h0, 32'hCAFE_0000,  OKAY,   "rd ro0"});
    vecs.push_back(vec_t'{1'b0, 6'h14, 32'h0,         4'h0, 32'h1234_5678,  OKAY,   "rd ro1"});
    vecs.push_back(vec_t'{1'b1, 6'h14, 32'hFFFF_FFFF, 4'hF, 32'h0,          OKAY,   "wr ro1 ignored"});
    vecs.push_back(vec_t'{1'b0, 6'h14, 32'h0,         4'h0, 32'h1234_5678,  OKAY,   "rd ro1 unchanged"});
    vecs.push_back(vec_t'{1'b0, 6'h24, 32'h0,         4'h0, 32'h0,          SLVERR, "rd unmapped 0x24"});
    vecs.push_back(vec_t'{1'b0, 6'h3C, 32'h0,         4'h0, 32'h0,          SLVERR, "rd unmapped 0x3C"});
    vecs.push_back(vec_t'{1'b1, 6'h24, 32'hDEAD_BEEF, 4'hF, 32'h0,          SLVERR, "wr unmapped 0x24"});
    vecs.push_back(vec_t'{1'b1, 6'h1C, 32'h0000_00F0, 4'hF, 32'h0,          OKAY,   "wr irq_en"});
    vecs.push_back(vec_t'{1'b0, 6'h1C, 32'h0,         4'h0, 32'h0000_00F0,  OKAY,   "rd irq_en"});
    vecs.push_back(vec_t'{1'b1, 6'h1C, 32'h1234_5601, 4'h1, 32'h0,          OKAY,   "wr irq_en byte0"});
    vecs.push_back(vec_t'{1'b0, 6'h1C, 32'h0,         4'h0, 32'h0000_0001,  OKAY,   "rd irq_en byte0"});
    vecs.push_back(vec_t'{1'b0, 6'h18, 32'h0,         4'h0, 32'h0,          OKAY,   "rd irq_stat idle"});
    vecs.push_back(vec_t'{1'b0, 6'h20, 32'h0,         4'h0, 32'h0,          OKAY,   "rd cmd reads zero"});

    // Reset values, checked while reset is still asserted
    #1;
    check_output("reset awready", 64'(bus.awready), 64'h0);
    check_output("reset bvalid",  64'(bus.bvalid),  64'h0);
    check_output("reset rvalid",  64'(bus.rvalid),  64'h0);
    check_output("reset rdata",   64'(bus.rdata),   64'h0);
    check_output("reset ctrl_out", 64'(ctrl_out[63:0]), 64'h0);
    check_output("reset irq",     64'(irq),         64'h0);
    check_output("reset cmd",     64'(cmd_pulse),   64'h0);
    step();
    step();
    ARESET = 1'b0;
    step();
    step();
    check_output("idle awready", 64'(bus.awready), 64'h1);
    check_output("idle arready", 64'(bus.arready), 64'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
    end

    check_output("ctrl_out slice0", 64'(ctrl_out[0*DW +: DW]), 64'h0000_0001);
    check_output("ctrl_out slice1", 64'(ctrl_out[1*DW +: DW]), 64'h00BB_00DD);
    check_output("ctrl_out slice2", 64'(ctrl_out[2*DW +: DW]), 64'h0000_0003);
    check_output("ctrl_out slice3", 64'(ctrl_out[3*DW +: DW]), 64'h0000_0004);

    // W leads AW by three cycles; response held off for four cycles
    bus.awaddr = 6'h08;
    bus.wdata  = 32'h0000_0055;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    check_output("W early wready drops", 64'(bus.wready), 64'h0);
    step();
    step();
    check_output("W early no bvalid", 64'(bus.bvalid), 64'h0);
    check_output("W early no update", 64'(ctrl_out[2*DW +: DW]), 64'h0000_0003);
    bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < TIMEOUT) begin
      step();
      n++;
    end
    if (!bus.bvalid) timeout_fail("late AW bvalid");
    for (int c = 0; c < 4; c++) begin
      check_output("bvalid held", 64'(bus.bvalid), 64'h1);
      check_output("awready low while bvalid", 64'({bus.awready, bus.wready}), 64'h0);
      step();
    end
    check_output("late AW update", 64'(ctrl_out[2*DW +: DW]), 64'h0000_0055);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check_output("bvalid after ack", 64'(bus.bvalid), 64'h0);
    step();
    check_output("ready after ack", 64'({bus.awready, bus.wready}), 64'h3);

    // Interrupt: one-cycle latency from IRQ_STAT, set beats coincident W1C
    check_output("irq quiet", 64'(irq), 64'h0);
    irq_evt = 32'h1;
    step();
    irq_evt = '0;
    check_output("irq latency", 64'(irq), 64'h0);
    step();
    check_output("irq raised", 64'(irq), 64'h1);
    bus.awaddr  = 6'h18;
    bus.wdata   = 32'h1;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    irq_evt     = 32'h1;
    step();
    irq_evt = '0;
    check_output("w1c coincident bvalid", 64'(bus.bvalid), 64'h1);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    axi_read(6'h18, rd, rsp);
    check_output("irq_stat set wins", 64'(rd), 64'h1);
    check_output("irq still high", 64'(irq), 64'h1);
    axi_write(6'h18, 32'h1, 4'hF, rsp);
    check_output("w1c bresp", 64'(rsp), 64'(OKAY));
    step();
    check_output("irq cleared", 64'(irq), 64'h0);
    irq_evt = 32'h10;
    step();
    irq_evt = '0;
    step();
    step();
    check_output("masked event no irq", 64'(irq), 64'h0);
    axi_read(6'h18, rd, rsp);
    check_output("masked event latched", 64'(rd), 64'h10);

    // Command pulse is strobe-masked and lasts one cycle
    bus.awaddr  = 6'h20;
    bus.wdata   = 32'h0000_FF05;
    bus.wstrb   = 4'h1;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check_output("cmd before commit", 64'(cmd_pulse), 64'h0);
    step();
    check_output("cmd pulse", 64'(cmd_pulse), 64'h5);
    check_output("cmd bvalid", 64'(bus.bvalid), 64'h1);
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check_output("cmd pulse ends", 64'(cmd_pulse), 64'h0);
    axi_read(6'h20, rd, rsp);
    check_output("cmd readback", 64'(rd), 64'h0);

    // Reset while the write response is pending
    bus.awaddr  = 6'h00;
    bus.wdata   = 32'h0000_0077;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    step();
    check_output("pre-reset bvalid", 64'(bus.bvalid), 64'h1);
    check_output("pre-reset ctrl", 64'(ctrl_out[0*DW +: DW]), 64'h0000_0077);
    ARESET = 1'b1;
    #1;
    check_output("async reset bvalid", 64'(bus.bvalid), 64'h0);
    check_output("async reset ctrl_out", 64'(ctrl_out[63:0]), 64'h0);
    step();
    ARESET     = 1'b0;
    bus.bready = 1'b1;
    step();
    step();
    step();
    check_output("no response after reset", 64'(bus.bvalid), 64'h0);
    check_output("awready after reset", 64'(bus.awready), 64'h1);
    bus.bready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so a stuck handshake can never hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pl_ctrl_regs_axil.md
Name: pl_ctrl_regs_axil

Overview:
Parametrised AXI4-Lite slave register bank for the PL control unit, generalising the fixed four-register control block. It provides N read/write control registers, M read-only status registers, a write-1-to-clear interrupt status register with enable mask, and a self-clearing command-pulse register. It sits between the PS master (via interconnect) and PL datapath logic.

Parameters:
C_DATA_WIDTH, 32, AXI data width and register width; 32 or 64.
C_ADDR_WIDTH, 6, AXI byte address width; must cover all (C_NUM_RW+C_NUM_RO+3) registers.
C_NUM_RW, 4, number of read/write control registers (1..16).
C_NUM_RO, 2, number of read-only status registers (0..16).

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  C_ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake
S_AXI_WDATA  in  C_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_DATA_WIDTH/8  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake
S_AXI_ARADDR  in  C_ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake
S_AXI_RDATA  out  C_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake
ctrl_out  out  C_NUM_RW*C_DATA_WIDTH  RW register contents, reg k at slice k
status_in  in  C_NUM_RO*C_DATA_WIDTH  RO register sources, sampled on read
irq_evt  in  C_DATA_WIDTH  per-bit interrupt event pulses
cmd_pulse  out  C_DATA_WIDTH  one-cycle command strobes
irq  out  1  registered interrupt request

Behaviour:
- Clock ACLK, reset ARESET asynchronous active-high. Reset values: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, ctrl_out 0, IRQ_STAT 0, IRQ_EN 0, cmd_pulse 0, irq 0. Reset mid-transaction aborts it; no response is issued afterwards.
- Map (B = C_DATA_WIDTH/8, index i at byte i*B, low log2(B) address bits ignored): i in [0,C_NUM_RW) RW; next C_NUM_RO indices RO; then IRQ_STAT (W1C), IRQ_EN (RW), CMD (write-only, reads 0). Any higher index is unmapped.
- Write channel: AW and W accepted independently; AWREADY high in idle until AW captured, WREADY likewise for W; each deasserts after its handshake. Once both are held, register update occurs on the next edge, with BVALID rising that same edge. BVALID holds until BREADY; then AWREADY/WREADY reassert the next cycle. One outstanding write maximum.
- WSTRB applies per byte to RW and IRQ_EN; to IRQ_STAT, only strobed bytes clear; CMD drives cmd_pulse=WDATA&strobe-mask for exactly one cycle. Writes to RO are ignored with BRESP=OKAY; writes to unmapped indices are ignored with BRESP=SLVERR (2'b10).
- Read channel: ARREADY high in idle; on AR handshake, RDATA/RRESP are registered and RVALID rises next edge; held stable until RREADY; ARREADY reasserts the following cycle. Unmapped reads: RDATA=0, RRESP=SLVERR. One outstanding read maximum; read and write channels are fully concurrent.
- Same-edge read and write to same register: read returns pre-write value.
- IRQ_STAT[b] sets on irq_evt[b]=1; on the same cycle as a W1C of that bit, set wins. irq = |(IRQ_STAT & IRQ_EN), registered (1-cycle latency from the state change).

Test Plan:
- Reset then write 0x00000001..0x00000004 to 0x00,0x04,0x08,0x0C; read back -> equal data, RRESP=OKAY, ctrl_out slices match.
- Write 0xAABBCCDD to 0x04 with WSTRB=4'b0101 over previous 0x00000002 -> reads 0x00BB00DD.
- W asserted 3 cycles before AW, BREADY held low 4 cycles -> single update, BVALID stays high until BREADY, no second accept.
- status_in slice 1 = 0x12345678, read 0x14 -> 0x12345678; write 0xFFFFFFFF to 0x14 -> BRESP OKAY, value unchanged; read 0x24 -> RDATA 0, RRESP SLVERR.
- IRQ_EN=0x1, pulse irq_evt[0] -> irq high 1 cycle later; W1C 0x1 to 0x18 coincident with new irq_evt[0] -> bit stays set; later W1C alone -> irq low.
- Write 0x00000005 to 0x20 -> cmd_pulse=0x5 for exactly one cycle; read 0x20 -> 0; assert ARESET during BVALID wait -> BVALID 0, ctrl_out 0 immediately.
